// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: captures register-file writebacks and data-memory stores from
// the core and streams them to a host drain over valid/ready. It never back-pressures
// the core; events that do not fit are dropped and accounted for.
module commit_trace_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     rf_we_i,
    input  logic [4:0]               rf_addr_i,
    input  logic [31:0]              rf_data_i,
    input  logic                     mem_we_i,
    input  logic [8:0]               mem_addr_i,
    input  logic [31:0]              mem_data_i,
    input  logic [3:0]               mem_strb_i,
    output logic                     trace_valid_o,
    output logic [45:0]              trace_data_o,
    input  logic                     trace_ready_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = 46;

    logic          reg_ev, mem_ev, pop;
    logic [EW-1:0] reg_entry, mem_entry, first_entry;
    logic [CW-1:0] free;
    logic [1:0]    n_ev, n_push, n_drop;
    logic [PW-1:0] wr_ptr_nxt;
    logic [DROP_W:0] drop_sum;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    // Entry storage is deliberately not reset.
    logic [EW-1:0] mem_q [DEPTH];

    // Decode events and decide how many fit; space freed by a same-cycle pop is not reused.
    always_comb begin
        reg_ev      = rf_we_i && (rf_addr_i != 5'd0);
        mem_ev      = mem_we_i;
        reg_entry   = {1'b0, 4'b0, rf_addr_i, 4'hF, rf_data_i};
        mem_entry   = {1'b1, mem_addr_i, mem_strb_i, mem_data_i};
        // The reg entry always goes first, so a lone mem event takes the first slot.
        first_entry = reg_ev ? reg_entry : mem_entry;
        n_ev        = {1'b0, reg_ev} + {1'b0, mem_ev};
        free        = CW'(DEPTH) - count_q;
        if (free >= CW'(2)) begin
            n_push = n_ev;
        end else if (free == CW'(1)) begin
            n_push = (n_ev != 2'd0) ? 2'd1 : 2'd0;
        end else begin
            n_push = 2'd0;
        end
        n_drop     = n_ev - n_push;
        pop        = (count_q != '0) && trace_ready_i;
        wr_ptr_nxt = wr_ptr_q + PW'(1);
        drop_sum   = {1'b0, drop_cnt_q} + (DROP_W + 1)'(n_drop);
    end

    // Next-state for pointers, occupancy and drop accounting; clear overrides everything.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            wr_ptr_d   = wr_ptr_q + PW'(n_push);
            rd_ptr_d   = rd_ptr_q + PW'(pop);
            count_d    = count_q + CW'(n_push) - CW'(pop);
            overflow_d = overflow_q | (n_drop != 2'd0);
            drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        end
    end

    // Control state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Write accepted entries at the write pointer (and the slot after it for a dual push).
    always_ff @(posedge clk_i) begin
        if (!clear_i) begin
            if (n_push != 2'd0) begin
                mem_q[wr_ptr_q] <= first_entry;
            end
            if (n_push == 2'd2) begin
                mem_q[wr_ptr_nxt] <= mem_entry;
            end
        end
    end

    // Registered status straight out; head entry read combinationally from storage.
    always_comb begin
        trace_valid_o = (count_q != '0);
        trace_data_o  = mem_q[rd_ptr_q];
        count_o       = count_q;
        overflow_o    = overflow_q;
        drop_cnt_o    = drop_cnt_q;
    end

endmodule
